vga_canvas_ctrl: RTL

Parametrised VGA timing generator and cell-bitmap canvas for the handwriting-input path. Sits between the mouse/cursor tracker and the DNN input: it renders a GRID_W × GRID_H cell canvas plus a cursor square on the monitor, accepts pen/erase strokes, and clears the canvas with a sequenced wipe. The flattened bitmap drives the classifier. Compared with the previous generation it adds parametrised timing and grid geometry, single-clock sync generation, erase, sequenced clear, a busy flag, and frame-aligned cursor sampling.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_timing_gen.sv | 77 +++++++
 rtl/vga_canvas_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA canvas controller.
package vga_pkg;

    // Default 800x600 @ 60 Hz timing (40 MHz pixel clock)
    localparam int H_SYNC_DEF   = 128;
    localparam int H_BACK_DEF   = 88;
    localparam int H_ACTIVE_DEF = 800;
    localparam int H_FRONT_DEF  = 40;
    localparam int V_SYNC_DEF   = 4;
    localparam int V_BACK_DEF   = 23;
    localparam int V_ACTIVE_DEF = 600;
    localparam int V_FRONT_DEF  = 1;

    // Counter width; wide enough for the default line/frame totals and
    // for cursor coordinates plus the cursor size without wrapping.
    localparam int CNT_W = 12;

    localparam logic [3:0] BLANK = 4'h2;
    localparam logic [3:0] FULL  = 4'hF;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical counters, registered syncs and frame-start pulse.
// active/h_pos/v_pos are combinational from the current counter state so the
// parent can register colour in step with the registered syncs.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FRONT  = V_FRONT_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             hs_o,
    output logic             vs_o,
    output logic             frame_start_o,
    output logic             active_o,
    output logic [CNT_W-1:0] h_pos_o,
    output logic [CNT_W-1:0] v_pos_o
);

    localparam int H_LINE  = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_FRAME = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_LINE - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_FRAME - 1);
    localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_C  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_BEG = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_BEG = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_SYNC + V_BACK + V_ACTIVE);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             hs_q, vs_q, fs_q;

    // Next counter values: h wraps each line, v advances on the h wrap
    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
    end

    // Counters plus syncs/frame-start registered one clock behind the counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hs_q    <= (h_cnt_q >= H_SYNC_C);
            vs_q    <= (v_cnt_q >= V_SYNC_C);
            fs_q    <= (h_cnt_q == '0) && (v_cnt_q == '0);
        end
    end

    assign hs_o          = hs_q;
    assign vs_o          = vs_q;
    assign frame_start_o = fs_q;
    assign active_o      = (h_cnt_q >= H_ACT_BEG) && (h_cnt_q < H_ACT_END) &&
                           (v_cnt_q >= V_ACT_BEG) && (v_cnt_q < V_ACT_END);
    assign h_pos_o       = h_cnt_q - H_ACT_BEG;
    assign v_pos_o       = v_cnt_q - V_ACT_BEG;

endmodule

// File: rtl/vga_canvas_ctrl.sv
// Cell-bitmap canvas with cursor overlay, pen/erase writes and a column-wise
// sequenced clear, rendered over the VGA timing generator.
module vga_canvas_ctrl
    import vga_pkg::*;
#(
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BACK      = H_BACK_DEF,
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int H_FRONT     = H_FRONT_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_BACK      = V_BACK_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int V_FRONT     = V_FRONT_DEF,
    parameter int CELL_LOG2   = 4,
    parameter int GRID_W      = 32,
    parameter int GRID_H      = 32,
    parameter int CURSOR_SIZE = 8
) (
    input  logic                       clkVga,
    input  logic                       iRst,
    input  logic [10:0]                iCursorX,
    input  logic [10:0]                iCursorY,
    input  logic                       iPenDown,
    input  logic                       iErase,
    input  logic                       iClear,
    output logic                       oBusy,
    output logic                       oFrameStart,
    output logic                       oHs,
    output logic                       oVs,
    output logic [3:0]                 oRed,
    output logic [3:0]                 oGreen,
    output logic [3:0]                 oBlue,
    output logic [GRID_W*GRID_H-1:0]   oImage
);

    localparam int N_CELLS = GRID_W * GRID_H;
    localparam int IDX_W   = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;
    localparam int COL_W   = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(GRID_W - 1);

    logic             active;
    logic [CNT_W-1:0] h_pos, v_pos;

    logic [10:0]        cur_x_q, cur_y_q;
    state_e             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [N_CELLS-1:0] image_q, image_d;
    logic [3:0]         red_q, red_d, green_q, green_d, blue_q, blue_d;

    logic [10:0]      cell_x, cell_y;
    logic             cell_valid;
    logic [IDX_W-1:0] cell_idx;

    logic [CNT_W-1:0] cur_x_ext, cur_y_ext;
    logic [CNT_W-1:0] pix_cx, pix_cy;
    logic             in_cursor, in_canvas;
    logic [IDX_W-1:0] pix_idx;

    vga_timing_gen #(
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT)
    ) u_timing (
        .clk_i         (clkVga),
        .rst_i         (iRst),
        .hs_o          (oHs),
        .vs_o          (oVs),
        .frame_start_o (oFrameStart),
        .active_o      (active),
        .h_pos_o       (h_pos),
        .v_pos_o       (v_pos)
    );

    // Cursor is sampled once per frame so drawing and rendering never tear
    always_ff @(posedge clkVga or posedge iRst) begin
        if (iRst) begin
            cur_x_q <= '0;
            cur_y_q <= '0;
        end else if (oFrameStart) begin
            cur_x_q <= iCursorX;
            cur_y_q <= iCursorY;
        end
    end

    assign cell_x     = cur_x_q >> CELL_LOG2;
    assign cell_y     = cur_y_q >> CELL_LOG2;
    assign cell_valid = (32'(cell_x) < GRID_W) && (32'(cell_y) < GRID_H);
    assign cell_idx   = IDX_W'(int'(cell_x) * GRID_H + int'(cell_y));

    // FSM state, clear column and canvas registers
    always_ff @(posedge clkVga or posedge iRst) begin
        if (iRst) begin
            state_q <= IDLE;
            col_q   <= '0;
            image_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            image_q <= image_d;
        end
    end

    // Next state: pen/erase writes in IDLE, one column wiped per clock in CLEAR
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        image_d = image_q;
        case (state_q)
            IDLE: begin
                if (cell_valid) begin
                    if (iErase)
                        image_d[cell_idx] = 1'b0;
                    else if (iPenDown)
                        image_d[cell_idx] = 1'b1;
                end
                if (iClear) begin
                    state_d = CLEAR;
                    col_d   = '0;
                end
            end
            CLEAR: begin
                for (int r = 0; r < GRID_H; r++)
                    image_d[IDX_W'(int'(col_q) * GRID_H + r)] = 1'b0;
                col_d = col_q + 1'b1;
                if (col_q == COL_LAST)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cur_x_ext = CNT_W'(cur_x_q);
    assign cur_y_ext = CNT_W'(cur_y_q);
    assign in_cursor = (h_pos >= cur_x_ext) && (h_pos <= cur_x_ext + CNT_W'(CURSOR_SIZE)) &&
                       (v_pos >= cur_y_ext) && (v_pos <= cur_y_ext + CNT_W'(CURSOR_SIZE));
    assign pix_cx    = h_pos >> CELL_LOG2;
    assign pix_cy    = v_pos >> CELL_LOG2;
    assign in_canvas = (32'(pix_cx) < GRID_W) && (32'(pix_cy) < GRID_H);
    assign pix_idx   = IDX_W'(int'(pix_cx) * GRID_H + int'(pix_cy));

    // Colour priority: blanking, cursor, set cell, background
    always_comb begin
        red_d   = FULL;
        green_d = FULL;
        blue_d  = FULL;
        if (!active) begin
            red_d   = BLANK;
            green_d = BLANK;
            blue_d  = BLANK;
        end else if (in_cursor) begin
            red_d   = (!iErase && !iPenDown) ? FULL : 4'h0;
            green_d = (!iErase && iPenDown) ? FULL : 4'h0;
            blue_d  = iErase ? FULL : 4'h0;
        end else if (in_canvas && image_q[pix_idx]) begin
            green_d = 4'h0;
        end
    end

    // Colour registered so it lines up with the registered syncs
    always_ff @(posedge clkVga or posedge iRst) begin
        if (iRst) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    assign oRed   = red_q;
    assign oGreen = green_q;
    assign oBlue  = blue_q;
    assign oImage = image_q;
    assign oBusy  = (state_q == CLEAR);

endmodule
